// File: rtl/dc_offset_corr.sv
// DC offset correction loop: epoch sequencing for err_dc_gen, geared DC integrator, saturating subtract.
// Optional feature macro: DC_TRACK_GEAR_EN (IDLE->ACQ->TRK gear shift); epoch length set by `LFSR_LEN.
`ifndef LFSR_LEN
`define LFSR_LEN 4
`endif

module dc_offset_corr #(
  parameter int FRAC_BITS  = 12,
  parameter int MU_ACQ     = 2,
  parameter int MU_TRK     = 6,
  parameter int ACQ_EPOCHS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               freeze,
  input  logic signed [17:0] acc_dc_err,
  input  logic signed [17:0] sig_in,
  output logic signed [17:0] sig_out,
  output logic signed [17:0] dc_est,
  output logic               epoch_hold,
  output logic               locked
);

  localparam int L      = `LFSR_LEN;
  localparam int W      = 18 + FRAC_BITS;
  localparam int SH_ACQ = FRAC_BITS - MU_ACQ;
  localparam int SH_TRK = FRAC_BITS - MU_TRK;

  if (MU_ACQ > FRAC_BITS || MU_TRK > FRAC_BITS || ACQ_EPOCHS < 1 || ACQ_EPOCHS > 255) begin : g_bad_params
    $error("dc_offset_corr: illegal parameter set");
  end

`ifdef DC_TRACK_GEAR_EN
  typedef enum logic [1:0] {IDLE, ACQ, TRK} state_t;
  logic [7:0] acq_cnt;
`else
  typedef enum logic [1:0] {IDLE, TRK} state_t;
`endif

  state_t                state;
  logic [L-1:0]          cnt;
  logic signed [W-1:0]   dc_acc;
  logic signed [W-1:0]   err_ext;
  logic signed [W-1:0]   addend;
  logic signed [W:0]     acc_sum;
  logic signed [W-1:0]   acc_next;
  logic signed [18:0]    diff;
  logic signed [17:0]    corr;
  logic                  cnt_zero;
  logic                  upd;

  assign cnt_zero   = (cnt == '0);
  assign epoch_hold = (cnt == '1);
  assign upd        = clk_en & cnt_zero & ~freeze & (state != IDLE);

  always_comb begin
    err_ext = {{FRAC_BITS{acc_dc_err[17]}}, acc_dc_err};
`ifdef DC_TRACK_GEAR_EN
    addend = (state == ACQ) ? (err_ext <<< SH_ACQ) : (err_ext <<< SH_TRK);
`else
    addend = err_ext <<< SH_TRK;
`endif
    acc_sum = {dc_acc[W-1], dc_acc} + {addend[W-1], addend};
    // One guard bit is enough: both operands are W-bit signed.
    if (acc_sum[W] != acc_sum[W-1])
      acc_next = acc_sum[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      acc_next = acc_sum[W-1:0];
  end

  always_comb begin
    diff = {sig_in[17], sig_in} - {dc_est[17], dc_est};
    if (diff[18] != diff[17])
      corr = diff[18] ? 18'sh20000 : 18'sh1FFFF;
    else
      corr = diff[17:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      dc_acc  <= '0;
      dc_est  <= '0;
      sig_out <= '0;
      state   <= IDLE;
      locked  <= 1'b0;
`ifdef DC_TRACK_GEAR_EN
      acq_cnt <= '0;
`endif
    end else if (clk_en) begin
      cnt     <= cnt + 1'b1;
      sig_out <= corr;
      if (!freeze) begin
        dc_est <= dc_acc[17+FRAC_BITS:FRAC_BITS];
        if (upd)
          dc_acc <= acc_next;
        case (state)
          IDLE: if (cnt_zero) begin
`ifdef DC_TRACK_GEAR_EN
            state <= ACQ;
`else
            state  <= TRK;
            locked <= 1'b1;
`endif
          end
`ifdef DC_TRACK_GEAR_EN
          ACQ: if (upd) begin
            acq_cnt <= acq_cnt + 1'b1;
            if (acq_cnt == 8'(ACQ_EPOCHS - 1)) begin
              state  <= TRK;
              locked <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dc_offset_corr.sv
// Self-checking bench for dc_offset_corr: directed phases with random data against an arithmetic epoch model.
`ifndef LFSR_LEN
`define LFSR_LEN 4
`endif

module tb_dc_offset_corr;

  localparam int EPOCH = 1 << `LFSR_LEN;
`ifdef DC_TRACK_GEAR_EN
  localparam bit GEAR = 1'b1;
`else
  localparam bit GEAR = 1'b0;
`endif
  localparam longint ACC_MAX = (longint'(1) << 29) - 1;
  localparam longint ACC_MIN = -(longint'(1) << 29);

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               clk_en = 1'b0;
  logic               freeze = 1'b0;
  logic signed [17:0] acc_dc_err = '0;
  logic signed [17:0] sig_in = '0;
  logic signed [17:0] sig_out;
  logic signed [17:0] dc_est;
  logic               epoch_hold;
  logic               locked;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: position within epoch, update count, integrator in 2^-12 units.
  int     pos;
  bit     started;
  int     n_upd;
  longint acc_m, est_m, out_m;

  dc_offset_corr #(.FRAC_BITS(12), .MU_ACQ(2), .MU_TRK(6), .ACQ_EPOCHS(8)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .freeze(freeze),
    .acc_dc_err(acc_dc_err), .sig_in(sig_in), .sig_out(sig_out),
    .dc_est(dc_est), .epoch_hold(epoch_hold), .locked(locked)
  );

  always #5 clk = ~clk;

  function automatic longint clamp(longint v, longint lo, longint hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit lock_m;
    lock_m = GEAR ? (n_upd >= 8) : started;
    check("sig_out", 64'(sig_out), 64'(out_m));
    check("dc_est", 64'(dc_est), 64'(est_m));
    check("locked", 64'(locked), 64'(lock_m));
    check("epoch_hold", 64'(epoch_hold), 64'(pos == EPOCH - 1));
  endtask

  task automatic model_reset();
    pos = 0; started = 0; n_upd = 0; acc_m = 0; est_m = 0; out_m = 0;
  endtask

  task automatic step(input bit en, input bit frz, input longint err, input longint sig);
    longint old_acc, old_est;
    int mu;
    clk_en = en; freeze = frz; acc_dc_err = 18'(err); sig_in = 18'(sig);
    @(posedge clk);
    if (en) begin
      old_acc = acc_m; old_est = est_m;
      if (pos == 0 && !frz) begin
        if (!started) started = 1;
        else begin
          mu = (GEAR && n_upd < 8) ? 2 : 6;
          acc_m = clamp(acc_m + (err <<< (12 - mu)), ACC_MIN, ACC_MAX);
          n_upd++;
        end
      end
      if (!frz) est_m = old_acc >>> 12;
      out_m = clamp(sig - old_est, -131072, 131071);
      pos = (pos + 1) % EPOCH;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset(input bit en);
    clk_en = en; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    check_all();
  endtask

  function automatic longint rnd_sig();
    return longint'($urandom_range(262143)) - 131072;
  endfunction

  initial begin
    model_reset();
    do_reset(1'b0);
    do_reset(1'b1);

    // Constant error: acquisition steps, then tracking steps, random samples.
    for (int i = 0; i < EPOCH * 14; i++) step(1'b1, 1'b0, 1024, rnd_sig());

    // Directed correction points including negative saturation.
    step(1'b1, 1'b0, 1024, 1000);
    step(1'b1, 1'b0, 1024, -131000);
    step(1'b1, 1'b0, 1024, 131071);

    // Freeze spanning two update candidates, aligned just before cnt==0.
    while (pos != EPOCH - 1) step(1'b1, 1'b0, 1024, rnd_sig());
    for (int i = 0; i < EPOCH + 4; i++) step(1'b1, 1'b1, 1024, rnd_sig());
    for (int i = 0; i < EPOCH * 2; i++) step(1'b1, 1'b0, 1024, rnd_sig());

    // Random clk_en gaps, random errors, occasional freeze.
    for (int i = 0; i < EPOCH * 20; i++)
      step($urandom_range(3) != 0, $urandom_range(9) == 0,
           longint'($urandom_range(8191)) - 4096, rnd_sig());

    // Positive then negative integrator saturation.
    for (int i = 0; i < EPOCH * 80; i++) step(1'b1, 1'b0, 131071, rnd_sig());
    for (int i = 0; i < EPOCH * 140; i++) step(1'b1, 1'b0, -131072, rnd_sig());

    // Reset mid-acquisition, then verify the discarded first epoch and restart.
    do_reset(1'b0);
    for (int i = 0; i < EPOCH * 3 + 5; i++) step(1'b1, 1'b0, 2000, rnd_sig());
    do_reset(1'b0);
    for (int i = 0; i < EPOCH * 4; i++) step(1'b1, 1'b0, 1024, rnd_sig());
    for (int i = 0; i < EPOCH * 4; i++) step(1'b1, 1'b0, 1024, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
